psram_ctrl: RTL and testbench
=============================

# psram_ctrl

Responder side of the PSRAM request interface. It accepts single-word read/write requests from the picoBlaze front-end (`wr`/`rd` strobes, `ub`/`lb`, 23-bit address, 16-bit data) and executes them as asynchronous-mode cycles on the external CellularRAM. It answers with `op_begun`, `data_ok` and `op_finished`. It also gates all traffic behind a power-up wait that is reported on `ctrlr_good`.

## Interface
- `PWRUP_CYCLES`, default 15000: cycles from reset release to `ctrlr_good` (150 µs at 100 MHz).
- `ACCESS_CYCLES`, default 8: cycles CE#/OE# or CE#/WE# are held low per access; must be ≥2.
- `RECOVERY_CYCLES`, default 2: cycles with CE# high after an access; must be ≥1.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: asynchronous, active-high.
- `rd` in 1: read request, level; held by the initiator until `op_begun`.
- `wr` in 1: write request, level; held by the initiator until `op_begun`.
- `ub` in 1: upper byte enable, active-high.
- `lb` in 1: lower byte enable, active-high.
- `burst` in 1: ignored; every request is a single access.
- `addr` in 23: word address.
- `data_out` in 16: write data from the initiator.
- `data_in` out 16: registered read data.
- `data_ok` out 1: one-cycle pulse; `data_in` is valid in this cycle.
- `op_begun` out 1: one-cycle pulse; the request has been accepted.
- `op_finished` out 1: one-cycle pulse; the operation is complete.
- `ctrlr_good` out 1: power-up wait is done and requests are accepted.
- `mem_addr` out 23
- `mem_dq` inout 16
- `mem_ce_n` out 1
- `mem_oe_n` out 1
- `mem_we_n` out 1
- `mem_ub_n` out 1
- `mem_lb_n` out 1
- `mem_adv_n` out 1: tied 0 (asynchronous mode).
- `mem_clk` out 1: tied 0 (asynchronous mode).
- `mem_cre` out 1: tied 0 (asynchronous mode).

## Operation
- **Reset values.** All outputs are registered.
  - `data_in`=0.
  - `data_ok`=`op_begun`=`op_finished`=`ctrlr_good`=0.
  - `mem_ce_n`=`mem_oe_n`=`mem_we_n`=`mem_ub_n`=`mem_lb_n`=1.
  - `mem_addr`=0; `mem_dq` tri-stated.
- **States:** PWRUP, IDLE, RD_ACC, WR_ACC, RECOV.
- **PWRUP.** Counts `PWRUP_CYCLES`, then goes to IDLE and sets `ctrlr_good`=1. `ctrlr_good` stays 1 until reset. `rd`/`wr` are ignored in PWRUP.
- **IDLE.**
  - Samples `rd`/`wr` on every edge. `rd` has priority if both are high.
  - On acceptance, latches `addr`, `data_out`, `ub`, `lb` and a read/write flag, then enters RD_ACC or WR_ACC.
  - `op_begun` is high for the first cycle of the access state only. Requests that are still asserted are ignored outside IDLE.
- **RD_ACC.**
  - Drives CE#=0, OE#=0, WE#=1, UB#/LB# = inverted enables; `mem_dq` is tri-stated.
  - On the final access cycle's edge, captures `mem_dq` into `data_in`, then enters RECOV.
- **WR_ACC.**
  - Drives CE#=0, WE#=0, OE#=1, with `mem_dq` driving the latched data.
  - Enters RECOV after `ACCESS_CYCLES` cycles.
- **RECOV.**
  - CE#, OE#, WE#, UB#, LB# are all 1.
  - After a write, `mem_dq` stays driven during the first RECOV cycle to give data hold; it is tri-stated after that.
  - After a read, `data_ok`=1 in the first RECOV cycle.
  - `op_finished`=1 in the last RECOV cycle; the next state is IDLE.
- **No byte enables.** A request with `ub`=`lb`=0 is still accepted and runs the full timing with the same handshake pulses, but CE# is never asserted. `data_in` is not updated.
- **Read data.** `data_in` holds its last read value between reads.
- **Reset mid-operation.** The block returns to PWRUP immediately and asynchronously: strobes go high, `mem_dq` is released, `ctrlr_good`=0, and the power-up count restarts. No `op_finished` is issued.

## Timing
- Let A = `ACCESS_CYCLES` and R = `RECOVERY_CYCLES`. Cycle 0 is the IDLE cycle in which the request is sampled high.
- **Read:**
  - `op_begun` and strobes active: cycles 1..A.
  - `data_ok`: cycle A+1.
  - `op_finished`: cycle A+R.
  - IDLE again: cycle A+R+1, when the next request can be sampled.
- **Write:** identical, except there is no `data_ok` and `mem_dq` is driven in cycles 1..A+1.
- **Defaults (A=8, R=2):** read gives `op_begun`@1, `data_ok`@9, `op_finished`@10. The minimum request-to-request spacing is 11 cycles.
- **Counters.** One shared down-counter, 14 bits wide, is reloaded on each state entry. Parameters must fit this width.

## Structure
- **Package `psram_pkg`:**
  - State encoding enum.
  - Default timing constants: 15000 / 8 / 2.
  - Counter width constant: 14.
- **Sub-module `psram_timer`:** loadable down-counter that provides load and terminal-count outputs. It is used for PWRUP, the access states and RECOV.
- The `mem_dq` tri-state buffer and its output-enable register stay in the top level.

## Test plan
- **Power-up.** `PWRUP_CYCLES`=100; `rd` held high from reset release. Required: `ctrlr_good` rises at cycle 100; no CE# activity before that; the read is then accepted.
- **Read.** Request `rd`, `addr`=0x123456, `ub`=`lb`=1; the model returns 0xBEEF. Required:
  - `mem_addr`=0x123456;
  - CE#/OE# low for exactly 8 cycles;
  - `data_ok`@9 with `data_in`=0xBEEF;
  - `op_finished`@10.
- **Upper-byte write.** Request `wr`, `addr`=0x000001, `data_out`=0xA5C3, `ub`=1, `lb`=0. Required:
  - WE# low for 8 cycles;
  - UB#=0, LB#=1;
  - `mem_dq`=0xA5C3 through cycle 9;
  - no `data_ok`.
- **Simultaneous request.** `rd`=`wr`=1 together. Required: a read cycle; WE# stays 1.
- **Reset mid-write.** Assert `reset` in WR_ACC cycle 4. Required: WE#/CE# go high and `mem_dq` goes Z the same cycle; `ctrlr_good`=0; no `op_finished`.
- **No byte enables, then read.** Request with `ub`=`lb`=0, followed by a second read accepted at cycle 11. Required:
  - first request: pulses at cycles 1 and 10 with CE# never low;
  - second request: read accepted at cycle 11, `op_begun`@12.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared types and default timing for the asynchronous-mode CellularRAM controller.
package psram_pkg;

  localparam int CNT_W                = 14;
  localparam int PWRUP_CYCLES_DEF    = 15000;
  localparam int ACCESS_CYCLES_DEF   = 8;
  localparam int RECOVERY_CYCLES_DEF = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_RD_ACC,
    ST_WR_ACC,
    ST_RECOV
  } state_e;

  // The timer counts down to zero, so an N-cycle interval loads N-1.
  function automatic cnt_t cnt_load(input int cycles);
    return cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/psram_if.sv
// Request/response bus between the picoBlaze front-end (master) and psram_ctrl (slave).
interface psram_if;
  logic        rd;
  logic        wr;
  logic        ub;
  logic        lb;
  logic        burst;
  logic [22:0] addr;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        data_ok;
  logic        op_begun;
  logic        op_finished;
  logic        ctrlr_good;

  modport master (
    output rd, wr, ub, lb, burst, addr, data_out,
    input  data_in, data_ok, op_begun, op_finished, ctrlr_good
  );

  modport slave (
    input  rd, wr, ub, lb, burst, addr, data_out,
    output data_in, data_ok, op_begun, op_finished, ctrlr_good
  );
endinterface

// File: rtl/psram_timer.sv
// Loadable down-counter shared by all timed states; saturates at zero.
// tc_o flags the current count is zero, tc_nxt_o flags the next count will be.
module psram_timer
  import psram_pkg::*;
#(
  parameter cnt_t RST_VAL = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  cnt_t load_val_i,
  output logic tc_o,
  output logic tc_nxt_o
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - cnt_t'(1);
    else
      cnt_d = cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= RST_VAL;
    else       cnt_q <= cnt_d;
  end

  assign tc_o     = (cnt_q == '0);
  assign tc_nxt_o = (cnt_d == '0);

endmodule

// File: rtl/psram_ctrl.sv
// Single-word asynchronous-mode CellularRAM controller with power-up gate.
// Read: op_begun@1, strobes 1..A, data_ok@A+1, op_finished@A+R; all outputs registered.
module psram_ctrl
  import psram_pkg::*;
#(
  parameter int PWRUP_CYCLES    = PWRUP_CYCLES_DEF,
  parameter int ACCESS_CYCLES   = ACCESS_CYCLES_DEF,
  parameter int RECOVERY_CYCLES = RECOVERY_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  psram_if.slave      host,
  output logic [22:0] mem_addr,
  inout  wire  [15:0] mem_dq,
  output logic        mem_ce_n,
  output logic        mem_oe_n,
  output logic        mem_we_n,
  output logic        mem_ub_n,
  output logic        mem_lb_n,
  output logic        mem_adv_n,
  output logic        mem_clk,
  output logic        mem_cre
);

  localparam cnt_t PWRUP_LD = cnt_load(PWRUP_CYCLES);
  localparam cnt_t ACC_LD   = cnt_load(ACCESS_CYCLES);
  localparam cnt_t REC_LD   = cnt_load(RECOVERY_CYCLES);

  state_e      state_q, state_d;
  logic        tmr_load, tmr_tc, tmr_tc_nxt;
  cnt_t        tmr_val;

  logic [22:0] addr_q, addr_d;
  logic [15:0] wdat_q, wdat_d;
  logic        ub_q, ub_d, lb_q, lb_d;

  logic [15:0] data_in_q, data_in_d;
  logic        data_ok_q, data_ok_d, op_begun_q, op_begun_d;
  logic        op_fin_q, op_fin_d, good_q, good_d;
  logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic        ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic        acc_d, en_d;

  psram_timer #(.RST_VAL(PWRUP_LD)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc),
    .tc_nxt_o   (tmr_tc_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_PWRUP;
      addr_q  <= '0;
      wdat_q  <= '0;
      ub_q    <= 1'b0;
      lb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      ub_q    <= ub_d;
      lb_q    <= lb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    ub_d     = ub_q;
    lb_d     = lb_q;
    case (state_q)
      ST_PWRUP: if (tmr_tc) state_d = ST_IDLE;
      ST_IDLE: begin
        if (host.rd || host.wr) begin
          state_d  = host.rd ? ST_RD_ACC : ST_WR_ACC;
          tmr_load = 1'b1;
          tmr_val  = ACC_LD;
          addr_d   = host.addr;
          wdat_d   = host.data_out;
          ub_d     = host.ub;
          lb_d     = host.lb;
        end
      end
      ST_RD_ACC, ST_WR_ACC: begin
        if (tmr_tc) begin
          state_d  = ST_RECOV;
          tmr_load = 1'b1;
          tmr_val  = REC_LD;
        end
      end
      ST_RECOV: if (tmr_tc) state_d = ST_IDLE;
      default:  state_d = ST_PWRUP;
    endcase
  end

  // Output next-values come from state_d so each strobe lines up with its state.
  always_comb begin
    acc_d      = (state_d == ST_RD_ACC) || (state_d == ST_WR_ACC);
    en_d       = ub_d || lb_d;
    ce_n_d     = !(acc_d && en_d);
    oe_n_d     = !((state_d == ST_RD_ACC) && en_d);
    we_n_d     = !((state_d == ST_WR_ACC) && en_d);
    ub_n_d     = !(acc_d && ub_d);
    lb_n_d     = !(acc_d && lb_d);
    dq_oe_d    = (state_d == ST_WR_ACC) ||
                 ((state_q == ST_WR_ACC) && (state_d == ST_RECOV));
    op_begun_d = acc_d && (state_q == ST_IDLE);
    data_ok_d  = (state_q == ST_RD_ACC) && (state_d == ST_RECOV);
    op_fin_d   = (state_d == ST_RECOV) && tmr_tc_nxt;
    good_d     = good_q || (state_d == ST_IDLE);
    data_in_d  = data_in_q;
    if ((state_q == ST_RD_ACC) && tmr_tc && (ub_q || lb_q))
      data_in_d = mem_dq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_in_q  <= '0;
      data_ok_q  <= 1'b0;
      op_begun_q <= 1'b0;
      op_fin_q   <= 1'b0;
      good_q     <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      ub_n_q     <= 1'b1;
      lb_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
    end else begin
      data_in_q  <= data_in_d;
      data_ok_q  <= data_ok_d;
      op_begun_q <= op_begun_d;
      op_fin_q   <= op_fin_d;
      good_q     <= good_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      ub_n_q     <= ub_n_d;
      lb_n_q     <= lb_n_d;
      dq_oe_q    <= dq_oe_d;
    end
  end

  assign mem_dq           = dq_oe_q ? wdat_q : 16'hzzzz;
  assign mem_addr         = addr_q;
  assign mem_ce_n         = ce_n_q;
  assign mem_oe_n         = oe_n_q;
  assign mem_we_n         = we_n_q;
  assign mem_ub_n         = ub_n_q;
  assign mem_lb_n         = lb_n_q;
  assign mem_adv_n        = 1'b0;
  assign mem_clk          = 1'b0;
  assign mem_cre          = 1'b0;
  assign host.data_in     = data_in_q;
  assign host.data_ok     = data_ok_q;
  assign host.op_begun    = op_begun_q;
  assign host.op_finished = op_fin_q;
  assign host.ctrlr_good  = good_q;

endmodule

// File: tb/tb_psram_ctrl.sv
// Directed bench for psram_ctrl with a shortened power-up and a one-word memory model.
module tb_psram_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [22:0] mem_addr;
  wire  [15:0] mem_dq;
  logic        mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n;
  logic        mem_adv_n, mem_clk, mem_cre;
  logic [15:0] model_q;
  int          n_vec = 0;
  int          n_err = 0;

  psram_if bus ();

  psram_ctrl #(.PWRUP_CYCLES(100), .ACCESS_CYCLES(8), .RECOVERY_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .host      (bus),
    .mem_addr  (mem_addr),
    .mem_dq    (mem_dq),
    .mem_ce_n  (mem_ce_n),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n),
    .mem_ub_n  (mem_ub_n),
    .mem_lb_n  (mem_lb_n),
    .mem_adv_n (mem_adv_n),
    .mem_clk   (mem_clk),
    .mem_cre   (mem_cre)
  );

  // Memory model: drives read data only while OE# is low.
  assign mem_dq = (!mem_oe_n) ? model_q : 16'hzzzz;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the IDLE cycle in which the request is sampled (cycle 0); ends in cycle 10.
  task automatic run_op(input bit is_rd, input logic ub_e, input logic lb_e,
                        input logic [22:0] a, input logic [15:0] wd,
                        input logic [15:0] din_exp);
    bit acc, en;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin
        bus.rd = 1'b0;
        bus.wr = 1'b0;
      end
      acc = (c <= 8);
      en  = ub_e | lb_e;
      chk($sformatf("op_begun@%0d", c), bus.op_begun, c == 1);
      chk($sformatf("op_finished@%0d", c), bus.op_finished, c == 10);
      chk($sformatf("data_ok@%0d", c), bus.data_ok, is_rd && (c == 9));
      chk($sformatf("ce_n@%0d", c), mem_ce_n, !(acc && en));
      chk($sformatf("oe_n@%0d", c), mem_oe_n, !(acc && en && is_rd));
      chk($sformatf("we_n@%0d", c), mem_we_n, !(acc && en && !is_rd));
      chk($sformatf("ub_n@%0d", c), mem_ub_n, !(acc && ub_e));
      chk($sformatf("lb_n@%0d", c), mem_lb_n, !(acc && lb_e));
      if (acc) chk($sformatf("mem_addr@%0d", c), mem_addr, a);
      chk($sformatf("dq_oe@%0d", c), dut.dq_oe_q, !is_rd && (c <= 9));
      if (!is_rd && c <= 9) chk($sformatf("mem_dq@%0d", c), mem_dq, wd);
      if (c >= 9) chk($sformatf("data_in@%0d", c), bus.data_in, din_exp);
    end
  endtask

  initial begin
    bit ce_seen, fin_seen;
    int wait_n;
    reset = 1'b1;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.ub = 1'b0; bus.lb = 1'b0; bus.burst = 1'b0;
    bus.addr = '0; bus.data_out = '0;
    model_q = 16'hBEEF;
    repeat (3) tick();

    chk("rst_ctrlr_good", bus.ctrlr_good, 1'b0);
    chk("rst_op_begun", bus.op_begun, 1'b0);
    chk("rst_data_ok", bus.data_ok, 1'b0);
    chk("rst_data_in", bus.data_in, 16'h0000);
    chk("rst_strobes", {mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n}, 5'b11111);
    chk("rst_mem_addr", mem_addr, 23'h0);
    chk("rst_dq_oe", dut.dq_oe_q, 1'b0);
    chk("tied_pins", {mem_adv_n, mem_clk, mem_cre}, 3'b000);

    // Power-up with a read already pending; the read doubles as the basic read test.
    bus.rd = 1'b1; bus.addr = 23'h123456; bus.ub = 1'b1; bus.lb = 1'b1;
    reset = 1'b0;
    ce_seen = 1'b0;
    for (int i = 1; i <= 99; i++) begin
      tick();
      if (!mem_ce_n || bus.op_begun) ce_seen = 1'b1;
    end
    chk("pwrup_good@99", bus.ctrlr_good, 1'b0);
    tick();
    chk("pwrup_good@100", bus.ctrlr_good, 1'b1);
    chk("pwrup_no_ce", ce_seen, 1'b0);
    run_op(1'b1, 1'b1, 1'b1, 23'h123456, 16'h0000, 16'hBEEF);

    // Upper-byte write.
    bus.wr = 1'b1; bus.addr = 23'h000001; bus.data_out = 16'hA5C3; bus.ub = 1'b1; bus.lb = 1'b0;
    tick();
    run_op(1'b0, 1'b1, 1'b0, 23'h000001, 16'hA5C3, 16'hBEEF);

    // Simultaneous read and write: read wins.
    model_q = 16'h1234;
    bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = 23'h7FFFFF; bus.ub = 1'b1; bus.lb = 1'b1;
    tick();
    run_op(1'b1, 1'b1, 1'b1, 23'h7FFFFF, 16'h0000, 16'h1234);

    // Reset during WR_ACC cycle 4.
    bus.wr = 1'b1; bus.addr = 23'h000002; bus.data_out = 16'h0F0F;
    tick();
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) bus.wr = 1'b0;
    end
    chk("midwr_we_low@4", mem_we_n, 1'b0);
    reset = 1'b1;
    #1;
    chk("midwr_we_n", mem_we_n, 1'b1);
    chk("midwr_ce_n", mem_ce_n, 1'b1);
    chk("midwr_dq_oe", dut.dq_oe_q, 1'b0);
    chk("midwr_good", bus.ctrlr_good, 1'b0);
    chk("midwr_data_in", bus.data_in, 16'h0000);
    repeat (2) tick();
    reset = 1'b0;
    fin_seen = 1'b0;
    wait_n = 0;
    for (int i = 1; i <= 150; i++) begin
      tick();
      if (bus.op_finished) fin_seen = 1'b1;
      if (bus.ctrlr_good) begin
        wait_n = i;
        break;
      end
    end
    chk("midwr_no_finish", fin_seen, 1'b0);
    chk("repwrup_cycles", wait_n, 100);

    // No byte enables, then a read accepted at cycle 11.
    bus.wr = 1'b1; bus.addr = 23'h000003; bus.data_out = 16'hFFFF; bus.ub = 1'b0; bus.lb = 1'b0;
    run_op(1'b0, 1'b0, 1'b0, 23'h000003, 16'hFFFF, 16'h0000);
    model_q = 16'h5A5A;
    bus.rd = 1'b1; bus.addr = 23'h0ABCDE; bus.ub = 1'b1; bus.lb = 1'b1;
    tick();
    chk("noen_idle_op_begun@11", bus.op_begun, 1'b0);
    chk("noen_idle_ce_n@11", mem_ce_n, 1'b1);
    run_op(1'b1, 1'b1, 1'b1, 23'h0ABCDE, 16'h0000, 16'h5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
